subgraph_scheduler: RTL

Walks the node_info BRAM from address 0 to TOTAL_NODES-1, splits the node stream into subgraphs using source_node_flag and num_of_nodes, and issues one row descriptor per node to the SPMM (H×W) engine. It also issues one descriptor per subgraph to the DMVM/softmax/aggregator chain. It sits between the preloaded node_info/H BRAMs and the compute pipeline, and is the top-level sequencer of one GAT layer pass.

---
 rtl/gat_pkg.sv | 40 ++++
 rtl/subgraph_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gat_pkg.sv
// Shared GAT layer types and default sizing for the scheduler and its neighbours.
// One node_info entry describes one graph node: its subgraph role and its H row length.
package gat_pkg;

  localparam int unsigned TOTAL_NODES      = 5;
  localparam int unsigned NUM_SUBGRAPHS    = 2;
  localparam int unsigned NODE_INFO_ADDR_W = 8;
  localparam int unsigned H_DATA_ADDR_W    = 12;
  localparam int unsigned ROW_LEN_WIDTH    = 8;
  localparam int unsigned NUM_NODE_WIDTH   = 8;
  localparam int unsigned NUM_NODE_ADDR_W  = 8;

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0]  row_length;
    logic [NUM_NODE_WIDTH-1:0] num_of_nodes;
    logic                      source_node_flag;
  } node_info_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSg,
    StRow,
    StFin
  } sched_state_e;

  typedef struct packed {
    logic [H_DATA_ADDR_W-1:0] h_addr;
    logic [ROW_LEN_WIDTH-1:0] row_len;
    logic                     src;
    logic                     last;
  } row_desc_t;

  typedef struct packed {
    logic [NUM_NODE_WIDTH-1:0]  num_of_nodes;
    logic [NUM_NODE_ADDR_W-1:0] sg_idx;
  } sg_desc_t;

endpackage

// File: rtl/subgraph_scheduler.sv
// Walks node_info once per start pulse, emitting one subgraph descriptor per source node
// and one row descriptor per node; flags malformed subgraph structure on err_o.
module subgraph_scheduler #(
  parameter int unsigned TOTAL_NODES      = gat_pkg::TOTAL_NODES,
  parameter int unsigned NUM_SUBGRAPHS    = gat_pkg::NUM_SUBGRAPHS,
  parameter int unsigned NODE_INFO_ADDR_W = gat_pkg::NODE_INFO_ADDR_W,
  parameter int unsigned H_DATA_ADDR_W    = gat_pkg::H_DATA_ADDR_W,
  parameter int unsigned ROW_LEN_WIDTH    = gat_pkg::ROW_LEN_WIDTH,
  parameter int unsigned NUM_NODE_WIDTH   = gat_pkg::NUM_NODE_WIDTH,
  parameter int unsigned NUM_NODE_ADDR_W  = gat_pkg::NUM_NODE_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  output logic [NODE_INFO_ADDR_W-1:0] ni_addr_o,
  output logic                        ni_en_o,
  input  gat_pkg::node_info_t         ni_dout_i,
  output logic                        row_valid_o,
  input  logic                        row_ready_i,
  output logic [H_DATA_ADDR_W-1:0]    row_h_addr_o,
  output logic [ROW_LEN_WIDTH-1:0]    row_len_o,
  output logic                        row_src_o,
  output logic                        row_last_o,
  output logic                        sg_valid_o,
  input  logic                        sg_ready_i,
  output logic [NUM_NODE_WIDTH-1:0]   sg_num_nodes_o,
  output logic [NUM_NODE_ADDR_W-1:0]  sg_idx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);
  import gat_pkg::*;

  sched_state_e                state_q;
  node_info_t                  info_q;
  logic [NODE_INFO_ADDR_W-1:0] node_idx_q;
  logic [H_DATA_ADDR_W-1:0]    h_addr_q;
  logic [NUM_NODE_ADDR_W-1:0]  sg_cnt_q;
  logic [NUM_NODE_WIDTH-1:0]   node_in_sg_q;
  logic [NUM_NODE_WIDTH-1:0]   sg_num_q;
  logic                        sg_open_q;
  logic                        err_q;
  logic                        ni_en_q;
  logic                        row_valid_q;
  logic                        sg_valid_q;
  logic                        done_q;

  logic                        row_last;
  logic                        sg_closes;
  logic                        sg_open_after;
  logic [NUM_NODE_ADDR_W-1:0]  sg_cnt_inc;
  logic [NUM_NODE_WIDTH-1:0]   sg_num_eff;
  row_desc_t                   row_desc;
  sg_desc_t                    sg_desc;

  // A row with no open subgraph is a stray node: it is closed on its own but never counted.
  assign row_last      = ~sg_open_q | (node_in_sg_q == sg_num_q - NUM_NODE_WIDTH'(1));
  assign sg_closes     = row_last & sg_open_q;
  assign sg_open_after = sg_open_q & ~row_last;
  assign sg_cnt_inc    = sg_cnt_q + NUM_NODE_ADDR_W'(sg_closes);
  assign sg_num_eff    = (info_q.num_of_nodes == '0) ? NUM_NODE_WIDTH'(1) : info_q.num_of_nodes;

  assign row_desc = '{
    h_addr:  h_addr_q,
    row_len: info_q.row_length,
    src:     info_q.source_node_flag,
    last:    row_valid_q & row_last
  };
  assign sg_desc = '{
    num_of_nodes: sg_valid_q ? sg_num_eff : '0,
    sg_idx:       sg_cnt_q
  };

  assign ni_addr_o      = node_idx_q;
  assign ni_en_o        = ni_en_q;
  assign row_valid_o    = row_valid_q;
  assign row_h_addr_o   = row_desc.h_addr;
  assign row_len_o      = row_desc.row_len;
  assign row_src_o      = row_desc.src;
  assign row_last_o     = row_desc.last;
  assign sg_valid_o     = sg_valid_q;
  assign sg_num_nodes_o = sg_desc.num_of_nodes;
  assign sg_idx_o       = sg_desc.sg_idx;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign err_o          = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      info_q       <= '0;
      node_idx_q   <= '0;
      h_addr_q     <= '0;
      sg_cnt_q     <= '0;
      node_in_sg_q <= '0;
      sg_num_q     <= '0;
      sg_open_q    <= 1'b0;
      err_q        <= 1'b0;
      ni_en_q      <= 1'b0;
      row_valid_q  <= 1'b0;
      sg_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q      <= StFetch;
            node_idx_q   <= '0;
            h_addr_q     <= '0;
            sg_cnt_q     <= '0;
            node_in_sg_q <= '0;
            sg_num_q     <= '0;
            sg_open_q    <= 1'b0;
            err_q        <= 1'b0;
            ni_en_q      <= 1'b1;
          end
        end
        StFetch: begin
          ni_en_q <= 1'b0;
          state_q <= StLoad;
        end
        StLoad: begin
          info_q <= ni_dout_i;
          if (ni_dout_i.source_node_flag) begin
            // Reopening before the previous subgraph filled, or a zero size, is malformed.
            if (sg_open_q || (ni_dout_i.num_of_nodes == '0)) err_q <= 1'b1;
            sg_valid_q <= 1'b1;
            state_q    <= StSg;
          end else begin
            if (!sg_open_q) err_q <= 1'b1;
            row_valid_q <= 1'b1;
            state_q     <= StRow;
          end
        end
        StSg: begin
          if (sg_ready_i) begin
            sg_num_q     <= sg_num_eff;
            node_in_sg_q <= '0;
            sg_open_q    <= 1'b1;
            sg_valid_q   <= 1'b0;
            row_valid_q  <= 1'b1;
            state_q      <= StRow;
          end
        end
        StRow: begin
          if (row_ready_i) begin
            row_valid_q  <= 1'b0;
            h_addr_q     <= h_addr_q + H_DATA_ADDR_W'(info_q.row_length);
            node_in_sg_q <= node_in_sg_q + NUM_NODE_WIDTH'(1);
            node_idx_q   <= node_idx_q + NODE_INFO_ADDR_W'(1);
            sg_cnt_q     <= sg_cnt_inc;
            sg_open_q    <= sg_open_after;
            if (node_idx_q == NODE_INFO_ADDR_W'(TOTAL_NODES - 1)) begin
              // Final tally folded in here so err_o is already valid alongside done_o.
              if ((sg_cnt_inc != NUM_NODE_ADDR_W'(NUM_SUBGRAPHS)) || sg_open_after) begin
                err_q <= 1'b1;
              end
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              ni_en_q <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
